// File: rtl/pixel_uart_sender_pkg.sv
// Shared types and constants for the frame-buffer to Nano UART path.
package fpga_nano_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } sender_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
  localparam int ADDR_W                    = 17;
  localparam int BYTES_PER_PIXEL           = 2;

  // Byte 0 is the zero-extended upper part of the pixel, byte 1 the low eight bits.
  function automatic logic [7:0] pixel_byte(input logic [15:0] px, input logic idx);
    return idx ? px[7:0] : px[15:8];
  endfunction

endpackage

// File: rtl/pixel_uart_sender_if.sv
// Pixel fetch handshake between the index generator / frame-buffer RAM and the sender.
interface pixel_uart_sender_if
  import fpga_nano_pkg::*;
#(
  parameter int PIXEL_W = 12
) ();

  // pixel_send_ready is a level, high only while the sender is idle. The index
  // generator may move pixel_addr only while it is high; an address change or a
  // start pulse seen by an idle sender is consumed in that same cycle, and
  // pixel_data must follow pixel_addr with the RAM read latency.
  logic                start;
  logic [ADDR_W-1:0]   pixel_addr;
  logic [PIXEL_W-1:0]  pixel_data;
  logic                pixel_send_ready;

  modport master (
    output start,
    output pixel_addr,
    output pixel_data,
    input  pixel_send_ready
  );

  modport slave (
    input  start,
    input  pixel_addr,
    input  pixel_data,
    output pixel_send_ready
  );

endinterface

// File: rtl/pixel_uart_sender_uart_byte_tx.sv
// One UART byte: start bit, eight data bits LSB first, optional even parity, stop bit.
// Define UART_PARITY_EN for 8E1 framing; otherwise the line is 8N1.
module uart_byte_tx
  import fpga_nano_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [7:0]    data,
  output logic          done,
  output logic          tx,
  output sender_state_t state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;
`ifdef UART_PARITY_EN
  logic             parity;
`endif

  assign bit_end = (clk_cnt == CNT_LAST);
  // Combinational so a new load can be accepted in the last stop cycle with no gap.
  assign done    = (state == STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx      <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (load && (state == IDLE || done)) begin
      state   <= START;
      tx      <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= data;
`ifdef UART_PARITY_EN
      parity  <= ^data;
`endif
    end else if (state != IDLE) begin
      clk_cnt <= bit_end ? '0 : clk_cnt + CNT_W'(1);
      if (bit_end) begin
        case (state)
          START: begin
            state <= DATA;
            tx    <= shreg[0];
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
              tx    <= parity;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end
`ifdef UART_PARITY_EN
          PARITY: begin
            state <= STOP;
            tx    <= 1'b1;
          end
`endif
          STOP: state <= IDLE;
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pixel_uart_sender.sv
// Fetches the pixel at the generator's address and ships it to the Nano as two UART bytes.
// UART_PARITY_EN (handled in uart_byte_tx) switches the framing from 8N1 to 8E1.
module pixel_uart_sender
  import fpga_nano_pkg::*;
#(
  parameter int NUM_PIXELS   = 320 * 240,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int RAM_LATENCY  = 1,
  parameter int PIXEL_W      = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  pixel_uart_sender_if.slave  pix,
  output logic                uart_tx,
  output logic                busy,
  output logic                frame_done,
  output sender_state_t       state_dbg
);

  localparam int LAT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RAM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(NUM_PIXELS);
  localparam logic              LAST_BYTE = 1'(BYTES_PER_PIXEL - 1);

  sender_state_t       state_q;
  sender_state_t       tx_state;
  logic [ADDR_W-1:0]   last_addr;
  logic [LAT_W-1:0]    lat_cnt;
  logic [PIXEL_W-1:0]  pixel_q;
  logic                byte_idx;
  logic                ready_q;
  logic                addr_changed;
  logic                trigger;
  logic                tx_load;
  logic                tx_done;
  logic [7:0]          tx_byte;

  assign addr_changed = (pix.pixel_addr != last_addr);
  assign trigger      = pix.start || (addr_changed && (pix.pixel_addr < END_ADDR));

  // START in this FSM means "a byte is in flight in uart_byte_tx".
  assign tx_load = (state_q == LOAD) || ((state_q == START) && tx_done && (byte_idx != LAST_BYTE));
  assign tx_byte = (state_q == LOAD) ? pixel_byte(16'(pix.pixel_data), 1'b0)
                                     : pixel_byte(16'(pixel_q), 1'b1);

  assign pix.pixel_send_ready = ready_q;
  assign state_dbg = (state_q == START) ? tx_state : state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_addr  <= '0;
      lat_cnt    <= '0;
      pixel_q    <= '0;
      byte_idx   <= 1'b0;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            last_addr <= pix.pixel_addr;
            lat_cnt   <= '0;
            state_q   <= FETCH;
            ready_q   <= 1'b0;
            busy      <= 1'b1;
          end else begin
            ready_q <= 1'b1;
            if (addr_changed) begin
              last_addr  <= pix.pixel_addr;
              frame_done <= (pix.pixel_addr == END_ADDR);
            end
          end
        end
        FETCH: begin
          if (lat_cnt == LAT_LAST) state_q <= LOAD;
          else                     lat_cnt <= lat_cnt + LAT_W'(1);
        end
        LOAD: begin
          pixel_q  <= pix.pixel_data;
          byte_idx <= 1'b0;
          state_q  <= START;
        end
        START: begin
          if (tx_done) begin
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
            end else begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .data  (tx_byte),
    .done  (tx_done),
    .tx    (uart_tx),
    .state (tx_state)
  );

endmodule

// File: tb/tb_pixel_uart_sender.sv
// Directed bench for pixel_uart_sender: a UART receiver monitor checks every byte against an expected queue.
module tb_pixel_uart_sender;
  import fpga_nano_pkg::*;

  localparam int CPB        = 4;
  localparam int NUM_PIX    = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic          clk;
  logic          rst_n;
  logic          uart_tx;
  logic          busy;
  logic          frame_done;
  sender_state_t state_dbg;

  pixel_uart_sender_if #(.PIXEL_W(12)) pix_if ();

  pixel_uart_sender #(
    .NUM_PIXELS   (NUM_PIX),
    .CLKS_PER_BIT (CPB),
    .RAM_LATENCY  (1),
    .PIXEL_W      (12)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (pix_if),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame-buffer RAM model, one cycle read latency
  logic [11:0] ram [0:15];
  always @(posedge clk) pix_if.pixel_data <= ram[pix_if.pixel_addr[3:0]];

  // scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int rx_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pixel(input logic [11:0] px);
    exp_q.push_back({4'h0, px[11:8]});
    exp_q.push_back(px[7:0]);
    n_pushed += 2;
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int n;
    n = 0;
    while (busy !== lvl && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, lvl);
  endtask

  // UART receive monitor, samples mid-bit on the falling clock edge
  logic       rx_active;
  int         rx_cnt;
  int         rx_slot;
  logic [7:0] rx_b;
  logic [7:0] rx_e;
  logic       rx_sb;
  logic       rx_pb;

  initial begin : rx_monitor
    rx_active = 1'b0;
    rx_cnt    = 0;
    rx_pb     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (uart_tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          rx_slot = rx_cnt / CPB;
          if (rx_slot == 0) rx_sb = uart_tx;
          else if (rx_slot <= 8) rx_b[rx_slot-1] = uart_tx;
          else if (rx_slot < FRAME_BITS - 1) rx_pb = uart_tx;
          else begin
            rx_active = 1'b0;
            rx_count++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL rx_unexpected_byte: got %02h, expected no byte", rx_b);
            end else begin
              rx_e = exp_q.pop_front();
              check("rx_byte", rx_b, rx_e);
              check("rx_start_bit", rx_sb, 1'b0);
              check("rx_stop_bit", uart_tx, 1'b1);
`ifdef UART_PARITY_EN
              check("rx_parity_bit", rx_pb, ^rx_e);
`endif
            end
          end
        end
      end
    end
  end

  int first_low;
  int last_busy;
  int rdy_bad;
  int fd_cnt;
  int fd_first;
  int low_cnt;
  int busy_cnt;

  initial begin
    ram[0] = 12'hABC; ram[1] = 12'h123; ram[2] = 12'h5A5; ram[3] = 12'hF0F;
    ram[4] = 12'h777; ram[5] = 12'h3C5; ram[6] = 12'h0BC; ram[7] = 12'hE61;
    for (int i = 8; i < 16; i++) ram[i] = 12'h000;
    rst_n = 1'b0;
    pix_if.start = 1'b0;
    pix_if.pixel_addr = '0;

    // 1: reset values, then ready one cycle after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_ready", pix_if.pixel_send_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", pix_if.pixel_send_ready, 1'b0);
    @(negedge clk);
    check("ready_after_release", pix_if.pixel_send_ready, 1'b1);

    // 2: start pulse sends 0x0A, 0xBC; start bit at trigger+3, busy through trigger+82
    @(posedge clk); #1 pix_if.start = 1'b1;
    push_pixel(12'hABC);
    @(posedge clk); #1 pix_if.start = 1'b0;
    first_low = -1; last_busy = -1; rdy_bad = 0;
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      if (uart_tx === 1'b0 && first_low < 0) first_low = c;
      if (busy === 1'b1) begin
        last_busy = c;
        if (pix_if.pixel_send_ready !== 1'b0) rdy_bad++;
      end else if (last_busy >= 0) break;
    end
    check("start_bit_latency", first_low, 3);
    check("busy_span", last_busy + 1, 2 * FRAME_BITS * CPB + 3);
    check("ready_low_while_busy", rdy_bad, 0);
    check("ready_after_pixel", pix_if.pixel_send_ready, 1'b1);

    // 3: address step while idle sends once, holding it does not resend
    @(posedge clk); #1 pix_if.pixel_addr = 17'd1;
    push_pixel(ram[1]);
    wait_busy(1'b1, "addr1_busy_rise");
    wait_busy(1'b0, "addr1_busy_fall");
    low_cnt = 0; busy_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx === 1'b0) low_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    check("hold_addr_no_tx", low_cnt, 0);
    check("hold_addr_no_busy", busy_cnt, 0);

    // 4: address change during transmission is picked up on return to idle
    @(posedge clk); #1 pix_if.pixel_addr = 17'd2;
    push_pixel(ram[2]);
    wait_busy(1'b1, "addr2_busy_rise");
    repeat (30) @(negedge clk);
    @(posedge clk); #1 pix_if.pixel_addr = 17'd3;
    push_pixel(ram[3]);
    wait_busy(1'b0, "addr2_busy_fall");
    @(negedge clk);
    check("addr3_auto_start", busy, 1'b1);
    wait_busy(1'b0, "addr3_busy_fall");

    // 5: end of frame, no transmission, single frame_done pulse
    @(posedge clk); #1 pix_if.pixel_addr = 17'(NUM_PIX);
    fd_cnt = 0; fd_first = -1; low_cnt = 0; rdy_bad = 0; busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = c;
      end
      if (uart_tx === 1'b0) low_cnt++;
      if (pix_if.pixel_send_ready !== 1'b1) rdy_bad++;
      if (busy === 1'b1) busy_cnt++;
    end
    check("frame_done_pulses", fd_cnt, 1);
    check("frame_done_timing", fd_first, 1);
    check("frame_end_no_tx", low_cnt, 0);
    check("frame_end_ready_high", rdy_bad, 0);
    check("frame_end_no_busy", busy_cnt, 0);

    // 6: reset during data bit 3 of byte 0x03 (pixel 0x3C5) aborts at once
    @(posedge clk); #1 pix_if.pixel_addr = 17'd5;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0; pix_if.pixel_addr = '0;
    @(negedge clk);
    check("abort_in_bit3_line", uart_tx, 1'b0);
    check("abort_in_bit3_state", 32'(state_dbg), 32'(DATA));
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_uart_tx", uart_tx, 1'b1);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    check("abort_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    low_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx === 1'b0) low_cnt++;
    end
    check("abort_no_more_bits", low_cnt, 0);

    // recovery pixel 0x0BC: bytes 0x00 and 0xBC (parity 1 in 8E1)
    @(posedge clk); #1 pix_if.pixel_addr = 17'd6;
    push_pixel(ram[6]);
    wait_busy(1'b1, "addr6_busy_rise");
    wait_busy(1'b0, "addr6_busy_fall");
    repeat (10) @(negedge clk);

    check("exp_queue_drained", exp_q.size(), 0);
    check("bytes_received", rx_count, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
